uart_tx_fifo: RTL

Byte FIFO with a transmit scheduler. It sits directly upstream of uart_tx and drives that block's send_trig/send_data pair. Producers such as uart_rx, command logic, or a bulk source write bytes in bursts. The block buffers them and issues exactly one single-cycle send_trig per byte, only when uart_tx is idle, so no byte is lost to the frame_begin = send_trig & ~tx_bsy gate.

---
 rtl/uart_pkg.sv | 12 +
 rtl/byte_fifo.sv | 52 +++++
 rtl/uart_tx_fifo.sv | 76 +++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, byte width and transmit scheduler state encoding.
package uart_pkg;
  localparam int SYSCLOCK = 27_000_000;
  localparam int BAUDRATE = 115_200;
  localparam int BYTE_W = 8;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH x 8 register FIFO with exact registered count/full/empty and overflow pulse.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);
  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              r_full, r_empty, r_overflow;
  logic              w_rd, w_wr;
  assign w_rd = rd_en && !r_empty;
  // a full FIFO still accepts a write when the same cycle frees a slot
  assign w_wr = wr_en && (!r_full || w_rd);
  assign w_count_nxt = r_count + (ADDR_W+1)'(w_wr) - (ADDR_W+1)'(w_rd);
  assign rd_data = r_mem[r_rd_ptr];
  assign full = r_full;
  assign empty = r_empty;
  assign count = r_count;
  assign overflow = r_overflow;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr   <= w_rd ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count    <= w_count_nxt;
      r_full     <= w_count_nxt == (ADDR_W+1)'(DEPTH);
      r_empty    <= w_count_nxt == '0;
      r_overflow <= wr_en && !w_wr;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers bytes and issues one send_trig per byte only while uart_tx is idle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              tx_bsy,
  output logic              send_trig,
  output logic [BYTE_W-1:0] send_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              ack_err
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  state_t            r_state;
  logic [TW-1:0]     r_tmo;
  logic              r_send_trig, r_ack_err;
  logic [BYTE_W-1:0] r_send_data, w_rd_data;
  logic              w_pop, w_empty;
  assign w_pop = (r_state == S_IDLE) && !w_empty && !tx_bsy;
  assign empty = w_empty;
  assign send_trig = r_send_trig;
  assign send_data = r_send_data;
  assign ack_err = r_ack_err;
  byte_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (w_pop),
    .rd_data  (w_rd_data),
    .full     (full),
    .empty    (w_empty),
    .count    (count),
    .overflow (overflow)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tmo       <= '0;
      r_send_trig <= 1'b0;
      r_send_data <= '0;
      r_ack_err   <= 1'b0;
    end else begin
      r_ack_err <= 1'b0;
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_send_data <= w_rd_data;
          r_send_trig <= 1'b1;
          r_state     <= S_ARM;
        end
        S_ARM: begin
          r_send_trig <= 1'b0;
          r_tmo       <= '0;
          r_state     <= S_WAIT_HI;
        end
        // a byte whose busy acknowledge never arrives is dropped, not retried
        S_WAIT_HI: if (tx_bsy) r_state <= S_WAIT_LO;
          else if (r_tmo == TW'(ACK_TIMEOUT - 1)) begin
            r_ack_err <= 1'b1;
            r_state   <= S_IDLE;
          end else r_tmo <= r_tmo + TW'(1);
        S_WAIT_LO: if (!tx_bsy) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
